// File: rtl/gemm_sched_pkg.sv
// Shared types and helpers for the GeMM tile scheduler.
// Optional perf counters: define GEMM_SCHED_PERF_EN.
package gemm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } sched_state_e;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

  // Skew drain: last operand crosses ArrM+ArrN-1 PE hops
  function automatic int unsigned flush_cycles(
    input int unsigned arr_m,
    input int unsigned arr_n
  );
    return arr_m + arr_n - 1;
  endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// Two-level tile walker: n_tile inner, m_tile outer, both wrap to 0.
// Used by gemm_tile_scheduler to step through output tiles.
module gemm_tile_counter
  import gemm_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         advance_i,
  input  logic [W-1:0] m_tiles_i,
  input  logic [W-1:0] n_tiles_i,
  output logic [W-1:0] m_tile_o,
  output logic [W-1:0] n_tile_o,
  output logic         last_tile_o
);

  logic [W-1:0] m_q, m_d;
  logic [W-1:0] n_q, n_d;
  logic         m_last, n_last;

  assign m_last = (m_q == m_tiles_i - W'(1));
  assign n_last = (n_q == n_tiles_i - W'(1));

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    if (clear_i) begin
      m_d = '0;
      n_d = '0;
    end else if (advance_i) begin
      if (n_last) begin
        n_d = '0;
        m_d = m_last ? '0 : m_q + W'(1);
      end else begin
        n_d = n_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q <= '0;
      n_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
    end
  end

  assign m_tile_o    = m_q;
  assign n_tile_o    = n_q;
  assign last_tile_o = m_last & n_last;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GeMM tile sequencer: clear, feed K, flush, drain.
// Optional perf counters: define GEMM_SCHED_PERF_EN.
module gemm_tile_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int ArrM          = 4,
  parameter int ArrN          = 4,
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     in_valid_i,
  input  logic                     c_ready_i,
  output logic [AddrWidth-1:0]     a_addr_o,
  output logic [AddrWidth-1:0]     b_addr_o,
  output logic                     fetch_o,
  output logic                     pe_clr_o,
  output logic                     pe_en_o,
  output logic                     feed_zero_o,
  output logic [$clog2(ArrM)-1:0]  drain_row_o,
  output logic [AddrWidth-1:0]     c_addr_o,
  output logic                     c_we_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef GEMM_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_cycles_o,
  output logic [31:0]              perf_in_stall_o,
  output logic [31:0]              perf_out_stall_o
`endif
);

  localparam int unsigned FlushCycles = flush_cycles(ArrM, ArrN);
  localparam int SW     = SizeAddrWidth;
  localparam int AW     = AddrWidth;
  localparam int RowW   = $clog2(ArrM);
  localparam int FlushW = $clog2(FlushCycles + 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(ArrM - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushCycles - 1);

  sched_state_e      state_q, state_d;
  logic [SW-1:0]     k_q, k_d;
  logic [SW-1:0]     k_size_q;
  logic [SW-1:0]     m_tiles_q, n_tiles_q;
  logic [FlushW-1:0] flush_q, flush_d;
  logic [RowW-1:0]   row_q, row_d;

  logic fetch_q;
  logic clr_q, feed_q, flush_en_q;
  logic we_q, busy_q, done_q;

  logic          take;
  logic          tile_clr, tile_adv;
  logic [SW-1:0] m_tile, n_tile;
  logic          last_tile;

  gemm_tile_counter #(
    .W(SW)
  ) u_tiles (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (tile_clr),
    .advance_i  (tile_adv),
    .m_tiles_i  (m_tiles_q),
    .n_tiles_i  (n_tiles_q),
    .m_tile_o   (m_tile),
    .n_tile_o   (n_tile),
    .last_tile_o(last_tile)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    flush_d  = flush_q;
    row_d    = row_q;
    take     = 1'b0;
    tile_clr = 1'b0;
    tile_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          take     = 1'b1;
          tile_clr = 1'b1;
          if (M_size_i == '0 || N_size_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        k_d     = '0;
        flush_d = '0;
        row_d   = '0;
        state_d = (k_size_q == '0) ? FLUSH : FEED;
      end
      FEED: begin
        if (in_valid_i) begin
          if (k_q == k_size_q - SW'(1)) begin
            state_d = FLUSH;
          end else begin
            k_d = k_q + SW'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == FlushLast) begin
          state_d = DRAIN;
        end else begin
          flush_d = flush_q + FlushW'(1);
        end
      end
      DRAIN: begin
        if (c_ready_i) begin
          if (row_q == LastRow) begin
            tile_adv = 1'b1;
            state_d  = last_tile ? DONE : CLEAR;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      k_q        <= '0;
      k_size_q   <= '0;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      flush_q    <= '0;
      row_q      <= '0;
      fetch_q    <= 1'b0;
      clr_q      <= 1'b0;
      feed_q     <= 1'b0;
      flush_en_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      flush_q    <= flush_d;
      row_q      <= row_d;
      fetch_q    <= fetch_o;
      clr_q      <= (state_d == CLEAR);
      feed_q     <= (state_d == FEED);
      flush_en_q <= (state_d == FLUSH);
      we_q       <= (state_d == DRAIN);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      if (take) begin
        k_size_q  <= K_size_i;
        m_tiles_q <= SW'(ceil_div(32'(M_size_i), ArrM));
        n_tiles_q <= SW'(ceil_div(32'(N_size_i), ArrN));
      end
    end
  end

  logic [AW-1:0] m_ext, n_ext, k_ext;
  logic [AW-1:0] ksz_ext, nt_ext, row_ext;

  always_comb begin
    m_ext   = AW'(m_tile);
    n_ext   = AW'(n_tile);
    k_ext   = AW'(k_q);
    ksz_ext = AW'(k_size_q);
    nt_ext  = AW'(n_tiles_q);
    row_ext = AW'(row_q);
  end

  assign a_addr_o = m_ext * ksz_ext + k_ext;
  assign b_addr_o = k_ext * nt_ext + n_ext;
  assign c_addr_o = (m_ext * AW'(ArrM) + row_ext) * nt_ext + n_ext;

  // SRAM read latency 1: operands reach the array one cycle after fetch
  assign fetch_o     = feed_q & in_valid_i;
  assign pe_en_o     = fetch_q | flush_en_q;
  assign pe_clr_o    = clr_q;
  assign feed_zero_o = flush_en_q;
  assign drain_row_o = row_q;
  assign c_we_o      = we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf_cyc_q, perf_in_q, perf_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cyc_q <= '0;
      perf_in_q  <= '0;
      perf_out_q <= '0;
    end else if (take) begin
      perf_cyc_q <= '0;
      perf_in_q  <= '0;
      perf_out_q <= '0;
    end else begin
      if (busy_q) begin
        perf_cyc_q <= perf_cyc_q + 32'd1;
      end
      if (feed_q && !in_valid_i) begin
        perf_in_q <= perf_in_q + 32'd1;
      end
      if (we_q && !c_ready_i) begin
        perf_out_q <= perf_out_q + 32'd1;
      end
    end
  end

  assign perf_cycles_o    = perf_cyc_q;
  assign perf_in_stall_o  = perf_in_q;
  assign perf_out_stall_o = perf_out_q;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: vector table plus reset corner.
// Perf checks compile in when GEMM_SCHED_PERF_EN is defined.
module tb_gemm_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  msz, ksz, nsz;
  logic        in_valid, c_ready;
  logic [15:0] a_addr_o, b_addr_o, c_addr_o;
  logic        fetch_o, pe_clr_o, pe_en_o, feed_zero_o;
  logic [1:0]  drain_row_o;
  logic        c_we_o, busy_o, done_o;
`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf_cycles_o, perf_in_stall_o, perf_out_stall_o;
`endif

  gemm_tile_scheduler dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .M_size_i   (msz),
    .K_size_i   (ksz),
    .N_size_i   (nsz),
    .in_valid_i (in_valid),
    .c_ready_i  (c_ready),
    .a_addr_o   (a_addr_o),
    .b_addr_o   (b_addr_o),
    .fetch_o    (fetch_o),
    .pe_clr_o   (pe_clr_o),
    .pe_en_o    (pe_en_o),
    .feed_zero_o(feed_zero_o),
    .drain_row_o(drain_row_o),
    .c_addr_o   (c_addr_o),
    .c_we_o     (c_we_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef GEMM_SCHED_PERF_EN
    ,
    .perf_cycles_o   (perf_cycles_o),
    .perf_in_stall_o (perf_in_stall_o),
    .perf_out_stall_o(perf_out_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int m;
    int k;
    int n;
    int ivmode;
    int crmode;
    int poke;
    int exp_done;
    int exp_install;
    int exp_outstall;
  } vec_t;

  vec_t vecs[9];

  int n_vec  = 0;
  int n_fail = 0;

  int f_cyc[$], f_a[$], f_b[$];
  int w_cyc[$], w_row[$], w_addr[$];
  int clr_cyc[$];
  int pe_cnt, fz_cnt, row2_cnt, done_cyc;
  int post_done, post_busy;
  int p_cyc, p_in, p_out;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int cyc;
    int stalls;
    f_cyc.delete(); f_a.delete(); f_b.delete();
    w_cyc.delete(); w_row.delete(); w_addr.delete();
    clr_cyc.delete();
    pe_cnt = 0; fz_cnt = 0; row2_cnt = 0; done_cyc = -1;
    p_cyc = 0; p_in = 0; p_out = 0;
    stalls = 0;
    @(posedge clk); #1;
    msz = v.m[7:0]; ksz = v.k[7:0]; nsz = v.n[7:0];
    start = 1'b1;
    in_valid = (v.ivmode != 0) ? 1'b0 : 1'b1;
    c_ready = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (fetch_o) begin
        f_cyc.push_back(cyc);
        f_a.push_back(int'(a_addr_o));
        f_b.push_back(int'(b_addr_o));
      end
      if (c_we_o && c_ready) begin
        w_cyc.push_back(cyc);
        w_row.push_back(int'(drain_row_o));
        w_addr.push_back(int'(c_addr_o));
      end
      if (pe_clr_o) clr_cyc.push_back(cyc);
      if (pe_en_o) pe_cnt++;
      if (feed_zero_o) fz_cnt++;
      if (c_we_o && drain_row_o == 2'd2 && c_addr_o == 16'd2) row2_cnt++;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (cyc >= 400) break;
      @(posedge clk); #1;
      cyc++;
      start = (v.poke != 0 && cyc == 5);
      msz = start ? 8'd8 : v.m[7:0];
      in_valid = (v.ivmode != 0) ? (cyc % 2 == 1) : 1'b1;
      if (v.crmode != 0 && c_we_o && drain_row_o == 2'd2 && stalls < 3) begin
        c_ready = 1'b0;
        stalls++;
      end else begin
        c_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    c_ready = 1'b1;
    @(negedge clk);
    post_done = int'(done_o);
    post_busy = int'(busy_o);
`ifdef GEMM_SCHED_PERF_EN
    p_cyc = int'(perf_cycles_o);
    p_in  = int'(perf_in_stall_o);
    p_out = int'(perf_out_stall_o);
`endif
  endtask

  task automatic check_job(input vec_t v);
    int mt, nt, tiles, tlen, j, t, zs;
    int cr_cyc[4];
    cr_cyc = '{13, 14, 18, 19};
    mt = (v.m + 3) / 4;
    nt = (v.n + 3) / 4;
    tiles = (v.m == 0 || v.n == 0) ? 0 : mt * nt;
    tlen = 1 + v.k + 7 + 4;
    zs = (v.ivmode == 0 && v.crmode == 0) ? 1 : 0;
    chk("done_cycle", done_cyc, v.exp_done);
    chk("done_one_cycle", post_done, 0);
    chk("idle_after_done", post_busy, 0);
    chk("fetch_count", f_a.size(), tiles * v.k);
    chk("write_count", w_addr.size(), tiles * 4);
    chk("clr_count", clr_cyc.size(), tiles);
    j = 0;
    for (int m = 0; m < mt && tiles > 0; m++) begin
      for (int n = 0; n < nt; n++) begin
        t = m * nt + n;
        if (zs != 0 && t < clr_cyc.size())
          chk("clr_cycle", clr_cyc[t], 1 + t * tlen);
        for (int k = 0; k < v.k; k++) begin
          if (j < f_a.size()) begin
            chk("a_addr", f_a[j], m * v.k + k);
            chk("b_addr", f_b[j], k * nt + n);
            if (zs != 0) chk("fetch_cycle", f_cyc[j], 2 + t * tlen + k);
            if (v.ivmode != 0) chk("stall_fetch_cycle", f_cyc[j], 3 + 2 * k);
          end
          j++;
        end
      end
    end
    j = 0;
    for (int m = 0; m < mt && tiles > 0; m++) begin
      for (int n = 0; n < nt; n++) begin
        t = m * nt + n;
        for (int r = 0; r < 4; r++) begin
          if (j < w_addr.size()) begin
            chk("drain_row", w_row[j], r);
            chk("c_addr", w_addr[j], (m * 4 + r) * nt + n);
            if (zs != 0) chk("write_cycle", w_cyc[j], 2 + t * tlen + v.k + 7 + r);
            if (v.crmode != 0) chk("stall_write_cycle", w_cyc[j], cr_cyc[r]);
          end
          j++;
        end
      end
    end
    if (zs != 0) begin
      chk("pe_en_cycles", pe_cnt, tiles * ((v.k > 0) ? v.k + 6 : 7));
      chk("feed_zero_cycles", fz_cnt, tiles * 7);
    end
    if (v.crmode != 0) chk("row2_hold_cycles", row2_cnt, 4);
`ifdef GEMM_SCHED_PERF_EN
    chk("perf_cycles", p_cyc, v.exp_done);
    chk("perf_in_stall", p_in, v.exp_install);
    chk("perf_out_stall", p_out, v.exp_outstall);
`endif
  endtask

  initial begin
    //         m  k  n  iv cr pk done ins outs
    vecs[0] = '{4, 4, 4, 0, 0, 0, 17, 0, 0};
    vecs[1] = '{8, 2, 8, 0, 0, 0, 57, 0, 0};
    vecs[2] = '{4, 4, 4, 1, 0, 0, 21, 4, 0};
    vecs[3] = '{4, 4, 4, 0, 1, 0, 20, 0, 3};
    vecs[4] = '{0, 4, 4, 0, 0, 0, 1, 0, 0};
    vecs[5] = '{4, 4, 0, 0, 0, 0, 1, 0, 0};
    vecs[6] = '{4, 0, 4, 0, 0, 0, 13, 0, 0};
    vecs[7] = '{5, 3, 6, 0, 0, 0, 61, 0, 0};
    vecs[8] = '{4, 4, 4, 0, 0, 1, 17, 0, 0};

    rst_n = 1'b1;
    start = 1'b0;
    msz = '0; ksz = '0; nsz = '0;
    in_valid = 1'b0;
    c_ready = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_fetch", int'(fetch_o), 0);
    chk("reset_we", int'(c_we_o), 0);
    chk("reset_pe_en", int'(pe_en_o), 0);
    chk("reset_pe_clr", int'(pe_clr_o), 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i]);
      check_job(vecs[i]);
    end

    // async reset in the middle of FEED, then a clean rerun
    @(posedge clk); #1;
    msz = 8'd4; ksz = 8'd4; nsz = 8'd4;
    in_valid = 1'b1; c_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midfeed_fetch", int'(fetch_o), 1);
    chk("midfeed_a_addr", int'(a_addr_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_fetch", int'(fetch_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_a_addr", int'(a_addr_o), 0);
    chk("midrst_b_addr", int'(b_addr_o), 0);
    chk("midrst_pe_en", int'(pe_en_o), 0);
    @(posedge clk); #1;
    chk("midrst_hold_done", int'(done_o), 0);
    chk("midrst_hold_we", int'(c_we_o), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy_o), 0);
    chk("post_rst_done", int'(done_o), 0);
    run_job(vecs[0]);
    check_job(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
